pd_serial_transmitter: RTL

Downstream consumer of the hash-separation word stream. Pulls 16-bit packet words (sync+PID, status, 18 hash/nonce words) one at a time via `read_enable`, serialises them MSB-first onto a single NRZI-encoded line paced by an external bit strobe, appends an end-of-packet marker, then pulses `data_sent` to rewind the upstream word counter. Sits between packet assembly and the pad driver.

---
 rtl/pd_serial_transmitter_pkg.sv | 18 +
 rtl/pd_serial_transmitter_if.sv | 21 ++
 rtl/pd_serial_transmitter_nrzi.sv | 63 ++++++
 rtl/pd_serial_transmitter.sv | 110 +++++++++++
 4 files changed

// File: rtl/pd_serial_transmitter_pkg.sv
// Shared types and constants for the PD serial transmitter.
package pd_tx_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SHIFT,
      EOP_LOW,
      EOP_HIGH,
      DONE
   } pd_tx_state_t;

   localparam int         PD_STUFF_RUN     = 6;
   localparam logic [7:0] PD_SYNC_BYTE     = 8'h80;
   localparam int         PD_EOP_LOW_BITS  = 2;
   localparam int         PD_EOP_HIGH_BITS = 1;

endpackage

// File: rtl/pd_serial_transmitter_if.sv
// Word-fetch / bit-pacing handshake plus serial line between upstream and the transmitter.
interface pd_serial_transmitter_if #(parameter int WORD_W = 16) ();
   logic              tx_start;
   logic [WORD_W-1:0] tx_data;
   logic              bit_strobe;
   logic              read_enable;
   logic              data_sent;
   logic              tx_busy;
   logic              d_out;
   logic              d_oe;

   modport master (
      output tx_start, tx_data, bit_strobe,
      input  read_enable, data_sent, tx_busy, d_out, d_oe
   );

   modport slave (
      input  tx_start, tx_data, bit_strobe,
      output read_enable, data_sent, tx_busy, d_out, d_oe
   );
endinterface

// File: rtl/pd_serial_transmitter_nrzi.sv
// NRZI line level register with optional bit stuffing (macro PD_BIT_STUFF_EN).
module pd_nrzi_encoder
   import pd_tx_pkg::*;
(
   input  logic clk,
   input  logic n_rst,
   input  logic shift_en,
   input  logic data_bit,
   input  logic eop_low,
   input  logic eop_high,
   input  logic run_clr,
   output logic level,
   output logic stall
);

`ifdef PD_BIT_STUFF_EN
   localparam int RUN_W = $clog2(PD_STUFF_RUN + 1);
   localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(PD_STUFF_RUN);

   logic [RUN_W-1:0] run;

   // A full run of ones turns the next data strobe into a stuffed toggle.
   assign stall = (run == RUN_MAX);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         level <= 1'b1;
         run   <= '0;
      end else begin
         if (run_clr) run <= '0;
         if (eop_low) begin
            level <= 1'b0;
         end else if (eop_high) begin
            level <= 1'b1;
         end else if (shift_en) begin
            if (stall || !data_bit) begin
               level <= ~level;
               run   <= '0;
            end else begin
               run <= run + 1'b1;
            end
         end
      end
   end
`else
   logic unused_run_clr;
   assign unused_run_clr = run_clr;
   assign stall = 1'b0;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         level <= 1'b1;
      end else if (eop_low) begin
         level <= 1'b0;
      end else if (eop_high) begin
         level <= 1'b1;
      end else if (shift_en && !data_bit) begin
         level <= ~level;
      end
   end
`endif

endmodule

// File: rtl/pd_serial_transmitter.sv
// Packet serialiser: fetches words, shifts MSB-first through the NRZI encoder, appends EOP.
// Optional bit stuffing is enabled by defining PD_BIT_STUFF_EN.
module pd_serial_transmitter
   import pd_tx_pkg::*;
#(
   parameter int NUM_WORDS    = 20,
   parameter int WORD_W       = 16,
   parameter int EOP_LOW_BITS = PD_EOP_LOW_BITS
) (
   input logic                    clk,
   input logic                    n_rst,
   pd_serial_transmitter_if.slave bus
);

   localparam int WC_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam int BC_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
   localparam int EC_W = (EOP_LOW_BITS > 1) ? $clog2(EOP_LOW_BITS) : 1;
   localparam logic [WC_W-1:0] LAST_WORD = WC_W'(NUM_WORDS - 1);
   localparam logic [BC_W-1:0] LAST_BIT  = BC_W'(WORD_W - 1);
   localparam logic [EC_W-1:0] LAST_EOP  = EC_W'(EOP_LOW_BITS - 1);

   pd_tx_state_t      state;
   logic [WC_W-1:0]   word_cnt;
   logic [BC_W-1:0]   bit_cnt;
   logic [EC_W-1:0]   eop_cnt;
   logic [WORD_W-1:0] shreg;
   logic              stall;
   logic              shift_en;

   assign shift_en = (state == SHIFT) && bus.bit_strobe;

   pd_nrzi_encoder u_nrzi (
      .clk      (clk),
      .n_rst    (n_rst),
      .shift_en (shift_en),
      .data_bit (shreg[WORD_W-1]),
      .eop_low  ((state == EOP_LOW) && bus.bit_strobe),
      .eop_high ((state == EOP_HIGH) && bus.bit_strobe),
      .run_clr  ((state == LOAD) && (word_cnt == '0)),
      .level    (bus.d_out),
      .stall    (stall)
   );

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state           <= IDLE;
         word_cnt        <= '0;
         bit_cnt         <= '0;
         eop_cnt         <= '0;
         shreg           <= '0;
         bus.read_enable <= 1'b0;
         bus.data_sent   <= 1'b0;
         bus.tx_busy     <= 1'b0;
         bus.d_oe        <= 1'b0;
      end else begin
         bus.read_enable <= 1'b0;
         bus.data_sent   <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.tx_start) begin
                  state       <= LOAD;
                  bus.tx_busy <= 1'b1;
               end
            end
            LOAD: begin
               shreg           <= bus.tx_data;
               bit_cnt         <= '0;
               bus.d_oe        <= 1'b1;
               // The final word needs no fetch; upstream is rewound by data_sent instead.
               bus.read_enable <= (word_cnt != LAST_WORD);
               state           <= SHIFT;
            end
            SHIFT: begin
               if (shift_en && !stall) begin
                  shreg <= {shreg[WORD_W-2:0], 1'b0};
                  if (bit_cnt != LAST_BIT) begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end else if (word_cnt != LAST_WORD) begin
                     word_cnt <= word_cnt + 1'b1;
                     state    <= LOAD;
                  end else begin
                     eop_cnt <= '0;
                     state   <= EOP_LOW;
                  end
               end
            end
            EOP_LOW: begin
               if (bus.bit_strobe) begin
                  if (eop_cnt == LAST_EOP) state <= EOP_HIGH;
                  else                     eop_cnt <= eop_cnt + 1'b1;
               end
            end
            EOP_HIGH: begin
               if (bus.bit_strobe) begin
                  bus.data_sent <= 1'b1;
                  state         <= DONE;
               end
            end
            DONE: begin
               bus.d_oe    <= 1'b0;
               bus.tx_busy <= 1'b0;
               word_cnt    <= '0;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
